iommu_cq_dispatcher: RTL and testbench

Sequencer between the command-queue fetch logic and the IOMMU's invalidation and fence resources. It accepts one 128-bit command-queue entry at a time and decodes it as IOTINVAL, IOFENCE or IODIR. It then drives the IOTLB, DDTC or PDTC invalidation handshakes, or the fence completion write and interrupt. It reports completion, illegal commands and fence memory faults to the CQ CSR logic.

---
 rtl/iommu_cq_dispatcher.sv | 176 +++++++++++++++++
 tb/tb_iommu_cq_dispatcher.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iommu_cq_dispatcher.sv
// IOMMU command-queue dispatcher: decodes one CQ entry at a time and
// sequences IOTLB/DDTC/PDTC invalidations and IOFENCE completion.
module iommu_cq_dispatcher (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cqen_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [127:0] cmd_i,
  output logic         tlb_inv_valid_o,
  input  logic         tlb_inv_ready_i,
  output logic         tlb_inv_gvma_o,
  output logic         tlb_inv_av_o,
  output logic         tlb_inv_pscv_o,
  output logic         tlb_inv_gv_o,
  output logic [19:0]  tlb_inv_pscid_o,
  output logic [15:0]  tlb_inv_gscid_o,
  output logic [51:0]  tlb_inv_vpn_o,
  output logic         ddtc_inv_valid_o,
  input  logic         ddtc_inv_ready_i,
  output logic         ddtc_inv_dv_o,
  output logic [23:0]  ddtc_inv_did_o,
  output logic         pdtc_inv_valid_o,
  input  logic         pdtc_inv_ready_i,
  output logic [23:0]  pdtc_inv_did_o,
  output logic [19:0]  pdtc_inv_pid_o,
  input  logic         outstanding_i,
  output logic         fence_wr_valid_o,
  input  logic         fence_wr_ready_i,
  output logic [63:0]  fence_wr_addr_o,
  output logic [31:0]  fence_wr_data_o,
  input  logic         fence_wr_done_i,
  input  logic         fence_wr_err_i,
  output logic         cmd_done_o,
  output logic         cmd_ill_o,
  output logic         cq_mf_o,
  output logic         fence_irq_o,
  output logic         busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_TLB, S_DDTC, S_PDTC,
    S_FWAIT, S_FWR, S_FRSP, S_ERR
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] cmd_q, cmd_d;
  logic         done_q, done_d;
  logic         ill_q, ill_d;
  logic         mf_q, mf_d;
  logic         irq_q, irq_d;

  logic [6:0] op;
  logic [2:0] f3;
  logic       accept;
  logic       is_tlb, is_ddtc, is_pdtc, is_fence;
  logic       unused_bits;

  assign op     = cmd_i[6:0];
  assign f3     = cmd_i[9:7];
  assign accept = cmd_valid_i & cmd_ready_o;

  // GVMA with PSCV and PDT without DV fall through to illegal
  assign is_tlb   = (op == 7'd1) &
                    ((f3 == 3'd0) | ((f3 == 3'd1) & ~cmd_i[32]));
  assign is_ddtc  = (op == 7'd3) & (f3 == 3'd0);
  assign is_pdtc  = (op == 7'd3) & (f3 == 3'd1) & cmd_i[33];
  assign is_fence = (op == 7'd2) & (f3 == 3'd0);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    mf_d    = 1'b0;
    irq_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d = cmd_i;
          unique case (1'b1)
            is_tlb:   state_d = S_TLB;
            is_ddtc:  state_d = S_DDTC;
            is_pdtc:  state_d = S_PDTC;
            is_fence: state_d = S_FWAIT;
            default: begin
              state_d = S_ERR;
              ill_d   = 1'b1;
            end
          endcase
        end
      end
      S_TLB: if (tlb_inv_ready_i) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_DDTC: if (ddtc_inv_ready_i) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_PDTC: if (pdtc_inv_ready_i) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_FWAIT: if (!outstanding_i) begin
        if (cmd_q[10]) begin
          state_d = S_FWR;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          irq_d   = cmd_q[11];
        end
      end
      S_FWR: if (fence_wr_ready_i) state_d = S_FRSP;
      S_FRSP: if (fence_wr_done_i) begin
        if (fence_wr_err_i) begin
          state_d = S_ERR;
          mf_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          irq_d   = cmd_q[11];
        end
      end
      S_ERR: if (!cqen_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      mf_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      mf_q    <= mf_d;
      irq_q   <= irq_d;
    end
  end

  assign cmd_ready_o      = (state_q == S_IDLE) & cqen_i;
  assign busy_o           = (state_q != S_IDLE);
  assign tlb_inv_valid_o  = (state_q == S_TLB);
  assign ddtc_inv_valid_o = (state_q == S_DDTC);
  assign pdtc_inv_valid_o = (state_q == S_PDTC);
  assign fence_wr_valid_o = (state_q == S_FWR);

  assign tlb_inv_gvma_o  = (cmd_q[9:7] == 3'd1);
  assign tlb_inv_av_o    = cmd_q[10];
  assign tlb_inv_pscv_o  = cmd_q[32];
  assign tlb_inv_gv_o    = cmd_q[33];
  assign tlb_inv_pscid_o = cmd_q[31:12];
  assign tlb_inv_gscid_o = cmd_q[59:44];
  assign tlb_inv_vpn_o   = cmd_q[125:74];
  assign ddtc_inv_dv_o   = cmd_q[33];
  assign ddtc_inv_did_o  = cmd_q[63:40];
  assign pdtc_inv_did_o  = cmd_q[63:40];
  assign pdtc_inv_pid_o  = cmd_q[31:12];
  assign fence_wr_addr_o = {cmd_q[125:64], 2'b00};
  assign fence_wr_data_o = cmd_q[63:32];

  assign cmd_done_o  = done_q;
  assign cmd_ill_o   = ill_q;
  assign cq_mf_o     = mf_q;
  assign fence_irq_o = irq_q;

  assign unused_bits = ^{cmd_q[127:126], cmd_q[6:0]};

endmodule

// File: tb/tb_iommu_cq_dispatcher.sv
// Bench for iommu_cq_dispatcher: directed scenarios plus random
// commands checked against a rule-level command model.
module tb_iommu_cq_dispatcher;

  localparam int K_ILL   = 0;
  localparam int K_TLB   = 1;
  localparam int K_DDTC  = 2;
  localparam int K_PDTC  = 3;
  localparam int K_FENCE = 4;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         cqen_i = 1'b1;
  logic         cmd_valid_i = 1'b0;
  logic         cmd_ready_o;
  logic [127:0] cmd_i = '0;
  logic         tlb_inv_valid_o, tlb_inv_ready_i = 1'b0;
  logic         tlb_inv_gvma_o, tlb_inv_av_o;
  logic         tlb_inv_pscv_o, tlb_inv_gv_o;
  logic [19:0]  tlb_inv_pscid_o;
  logic [15:0]  tlb_inv_gscid_o;
  logic [51:0]  tlb_inv_vpn_o;
  logic         ddtc_inv_valid_o, ddtc_inv_ready_i = 1'b0;
  logic         ddtc_inv_dv_o;
  logic [23:0]  ddtc_inv_did_o;
  logic         pdtc_inv_valid_o, pdtc_inv_ready_i = 1'b0;
  logic [23:0]  pdtc_inv_did_o;
  logic [19:0]  pdtc_inv_pid_o;
  logic         outstanding_i = 1'b0;
  logic         fence_wr_valid_o, fence_wr_ready_i = 1'b0;
  logic [63:0]  fence_wr_addr_o;
  logic [31:0]  fence_wr_data_o;
  logic         fence_wr_done_i = 1'b0, fence_wr_err_i = 1'b0;
  logic         cmd_done_o, cmd_ill_o, cq_mf_o, fence_irq_o, busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  iommu_cq_dispatcher dut (
    .clk_i(clk), .rst_ni(rst_ni), .cqen_i(cqen_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_i(cmd_i),
    .tlb_inv_valid_o(tlb_inv_valid_o),
    .tlb_inv_ready_i(tlb_inv_ready_i),
    .tlb_inv_gvma_o(tlb_inv_gvma_o), .tlb_inv_av_o(tlb_inv_av_o),
    .tlb_inv_pscv_o(tlb_inv_pscv_o), .tlb_inv_gv_o(tlb_inv_gv_o),
    .tlb_inv_pscid_o(tlb_inv_pscid_o),
    .tlb_inv_gscid_o(tlb_inv_gscid_o),
    .tlb_inv_vpn_o(tlb_inv_vpn_o),
    .ddtc_inv_valid_o(ddtc_inv_valid_o),
    .ddtc_inv_ready_i(ddtc_inv_ready_i),
    .ddtc_inv_dv_o(ddtc_inv_dv_o), .ddtc_inv_did_o(ddtc_inv_did_o),
    .pdtc_inv_valid_o(pdtc_inv_valid_o),
    .pdtc_inv_ready_i(pdtc_inv_ready_i),
    .pdtc_inv_did_o(pdtc_inv_did_o), .pdtc_inv_pid_o(pdtc_inv_pid_o),
    .outstanding_i(outstanding_i),
    .fence_wr_valid_o(fence_wr_valid_o),
    .fence_wr_ready_i(fence_wr_ready_i),
    .fence_wr_addr_o(fence_wr_addr_o),
    .fence_wr_data_o(fence_wr_data_o),
    .fence_wr_done_i(fence_wr_done_i),
    .fence_wr_err_i(fence_wr_err_i),
    .cmd_done_o(cmd_done_o), .cmd_ill_o(cmd_ill_o),
    .cq_mf_o(cq_mf_o), .fence_irq_o(fence_irq_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Command classification straight from the decode rules
  function automatic int model_kind(input logic [127:0] c);
    int op, f3;
    op = int'(c[6:0]);
    f3 = int'(c[9:7]);
    if (op == 1 && f3 == 0) return K_TLB;
    if (op == 1 && f3 == 1) return c[32] ? K_ILL : K_TLB;
    if (op == 3 && f3 == 0) return K_DDTC;
    if (op == 3 && f3 == 1) return c[33] ? K_PDTC : K_ILL;
    if (op == 2 && f3 == 0) return K_FENCE;
    return K_ILL;
  endfunction

  function automatic logic [127:0] exp_pay(input int k,
                                           input logic [127:0] c);
    logic [127:0] r;
    r = '0;
    if (k == K_TLB)
      r = {36'b0, (c[9:7] == 3'd1), c[10], c[32], c[33],
           c[31:12], c[59:44], c[125:74]};
    else if (k == K_DDTC)
      r = {103'b0, c[33], c[63:40]};
    else if (k == K_PDTC)
      r = {84'b0, c[63:40], c[31:12]};
    return r;
  endfunction

  function automatic logic [127:0] obs_pay(input int k);
    logic [127:0] r;
    r = '0;
    if (k == K_TLB)
      r = {36'b0, tlb_inv_gvma_o, tlb_inv_av_o, tlb_inv_pscv_o,
           tlb_inv_gv_o, tlb_inv_pscid_o, tlb_inv_gscid_o,
           tlb_inv_vpn_o};
    else if (k == K_DDTC)
      r = {103'b0, ddtc_inv_dv_o, ddtc_inv_did_o};
    else if (k == K_PDTC)
      r = {84'b0, pdtc_inv_did_o, pdtc_inv_pid_o};
    return r;
  endfunction

  function automatic logic [3:0] exp_vld(input int k);
    if (k == K_TLB)  return 4'b1000;
    if (k == K_DDTC) return 4'b0100;
    if (k == K_PDTC) return 4'b0010;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] obs_vld;
    return {tlb_inv_valid_o, ddtc_inv_valid_o,
            pdtc_inv_valid_o, fence_wr_valid_o};
  endfunction

  task automatic set_ready(input int k, input logic v);
    tlb_inv_ready_i  = (k == K_TLB)  & v;
    ddtc_inv_ready_i = (k == K_DDTC) & v;
    pdtc_inv_ready_i = (k == K_PDTC) & v;
  endtask

  task automatic recover;
    tick;
    chk("err_hold_busy", busy_o, 1);
    chk("err_hold_rdy", cmd_ready_o, 0);
    chk("err_no_done", cmd_done_o, 0);
    cqen_i = 1'b0;
    tick;
    chk("err_exit_idle", busy_o, 0);
    chk("err_exit_rdy", cmd_ready_o, 0);
    cqen_i = 1'b1;
    #1;
    chk("err_cqen_rdy", cmd_ready_o, 1);
  endtask

  // Issue one command and follow it to completion
  task automatic exec(input logic [127:0] c, input int dly,
                      input logic err);
    int k;
    k = model_kind(c);
    chk("accept_rdy", cmd_ready_o, 1);
    cmd_valid_i   = 1'b1;
    cmd_i         = c;
    outstanding_i = (k == K_FENCE) && (dly != 0);
    tick;
    cmd_valid_i = 1'b0;
    cmd_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    chk("busy", busy_o, 1);
    if (k == K_ILL) begin
      chk("ill_pulse", cmd_ill_o, 1);
      chk("ill_no_done", cmd_done_o, 0);
      chk("ill_rdy", cmd_ready_o, 0);
      chk("ill_vld", obs_vld(), 0);
      recover();
    end else if (k != K_FENCE) begin
      for (int i = 0; i < dly; i++) begin
        chk("inv_vld_hold", obs_vld(), exp_vld(k));
        chk("inv_pay", obs_pay(k), exp_pay(k, c));
        chk("inv_no_done", cmd_done_o, 0);
        tick;
      end
      chk("inv_vld", obs_vld(), exp_vld(k));
      chk("inv_pay_last", obs_pay(k), exp_pay(k, c));
      set_ready(k, 1'b1);
      tick;
      set_ready(k, 1'b0);
      chk("inv_vld_drop", obs_vld(), 0);
      chk("inv_done", cmd_done_o, 1);
      chk("inv_idle", busy_o, 0);
      chk("inv_rdy_back", cmd_ready_o, 1);
    end else begin
      for (int i = 0; i < dly; i++) begin
        chk("fw_no_wr", fence_wr_valid_o, 0);
        chk("fw_no_done", cmd_done_o, 0);
        tick;
      end
      outstanding_i = 1'b0;
      tick;
      if (!c[10]) begin
        chk("fn_done", cmd_done_o, 1);
        chk("fn_irq", fence_irq_o, c[11]);
        chk("fn_no_wr", fence_wr_valid_o, 0);
        chk("fn_idle", busy_o, 0);
      end else begin
        chk("fwr_vld", fence_wr_valid_o, 1);
        chk("fwr_addr", fence_wr_addr_o, {c[125:64], 2'b00});
        chk("fwr_data", fence_wr_data_o, c[63:32]);
        fence_wr_done_i = 1'b1;
        fence_wr_err_i  = err;
        tick;
        fence_wr_done_i = 1'b0;
        fence_wr_err_i  = 1'b0;
        chk("fwr_early_rsp", fence_wr_valid_o, 1);
        chk("fwr_early_mf", cq_mf_o, 0);
        chk("fwr_early_done", cmd_done_o, 0);
        fence_wr_ready_i = 1'b1;
        tick;
        fence_wr_ready_i = 1'b0;
        chk("frsp_vld", fence_wr_valid_o, 0);
        chk("frsp_busy", busy_o, 1);
        tick;
        chk("frsp_wait", cmd_done_o, 0);
        fence_wr_done_i = 1'b1;
        fence_wr_err_i  = err;
        tick;
        fence_wr_done_i = 1'b0;
        fence_wr_err_i  = 1'b0;
        chk("frsp_mf", cq_mf_o, err);
        chk("frsp_done", cmd_done_o, !err);
        chk("frsp_irq", fence_irq_o, !err && c[11]);
        chk("frsp_busy_end", busy_o, err);
        if (err) recover();
      end
    end
  endtask

  initial begin
    logic [127:0] c;
    #3;
    chk("rst_busy", busy_o, 0);
    chk("rst_rdy", cmd_ready_o, 1);
    chk("rst_vld", obs_vld(), 0);
    chk("rst_pulses", {cmd_done_o, cmd_ill_o, cq_mf_o, fence_irq_o}, 0);
    chk("rst_cmdq", tlb_inv_vpn_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick;

    c = '0;
    c[6:0] = 7'd1; c[10] = 1'b1; c[32] = 1'b1;
    c[31:12] = 20'h12345; c[125:74] = 52'hABCDE;
    exec(c, 3, 1'b0);
    chk("vma_gvma", tlb_inv_gvma_o, 0);

    c = '0;
    c[6:0] = 7'd3; c[9:7] = 3'd1; c[31:12] = 20'h777;
    exec(c, 0, 1'b0);
    c = '0;
    c[6:0] = 7'd4;
    exec(c, 0, 1'b0);
    c = '0;
    c[6:0] = 7'd1; c[9:7] = 3'd1; c[32] = 1'b1;
    exec(c, 0, 1'b0);

    ddtc_inv_ready_i = 1'b1;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c = '0;
      c[6:0] = 7'd3; c[33] = 1'b1;
      c[63:40] = 24'hABCDEF + 24'(i);
      cmd_i = c;
      chk("b2b_rdy", cmd_ready_o, 1);
      tick;
      chk("b2b_vld", ddtc_inv_valid_o, 1);
      chk("b2b_did", ddtc_inv_did_o, 24'hABCDEF + 24'(i));
      chk("b2b_dv", ddtc_inv_dv_o, 1);
      chk("b2b_rdy_lo", cmd_ready_o, 0);
      tick;
      chk("b2b_vld_1cyc", ddtc_inv_valid_o, 0);
      chk("b2b_done", cmd_done_o, 1);
    end
    cmd_valid_i = 1'b0;
    ddtc_inv_ready_i = 1'b0;

    c = '0;
    c[6:0] = 7'd2; c[10] = 1'b1; c[11] = 1'b1;
    c[63:32] = 32'hDEADBEEF; c[125:64] = 62'h4000;
    exec(c, 5, 1'b0);
    chk("fence_addr_dir", {c[125:64], 2'b00}, 64'h10000);
    exec(c, 0, 1'b1);
    c[10] = 1'b0;
    exec(c, 2, 1'b0);

    c = '0;
    c[6:0] = 7'd1; c[31:12] = 20'h5A5A5;
    cmd_valid_i = 1'b1;
    cmd_i = c;
    tick;
    cmd_valid_i = 1'b0;
    chk("rst_mid_vld", tlb_inv_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_mid_vld0", obs_vld(), 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_pay", tlb_inv_pscid_o, 0);
    chk("rst_mid_pulse", {cmd_done_o, cmd_ill_o}, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick;
    chk("rst_rel_done", cmd_done_o, 0);
    chk("rst_rel_busy", busy_o, 0);
    chk("rst_rel_rdy", cmd_ready_o, 1);

    for (int n = 0; n < 40; n++) begin
      c = {$urandom(), $urandom(), $urandom(), $urandom()};
      case ($urandom_range(0, 5))
        0, 1: c[6:0] = 7'd1;
        2, 3: c[6:0] = 7'd3;
        4:    c[6:0] = 7'd2;
        default: c[6:0] = 7'($urandom_range(0, 127));
      endcase
      c[9:7] = 3'($urandom_range(0, 2));
      exec(c, $urandom_range(0, 3), ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
